// File: rtl/pwm_capture_stereo.sv
// pwm_capture_stereo
//   Receive side of the stereo PWM audio link. Each PWM line is high for
//   "level" clocks at the start of a 2**PERIOD_LOG2-clock period; the level
//   is offset-binary and is returned as a signed sample. The block frame-locks
//   to rising edges and hands out one sample pair per period over valid/ready.
//
// Ports
//   clk_in            in   system clock, sole clock
//   rst_in            in   asynchronous active-high reset
//   pwm_in_l/r        in   PWM lines, asynchronous to clk_in
//   sample_l/r_out    out  signed recovered samples (PERIOD_LOG2 bits)
//   sample_valid_out  out  sample pair valid
//   sample_ready_in   in   consumer accepts the pair when valid && ready
//   locked_out        out  frame lock held
//   overrun_out       out  1-cycle pulse: unaccepted pair overwritten
//   misalign_out      out  1-cycle pulse: rising edge seen at phase != 0
`timescale 1ns/1ps
module pwm_capture_stereo #(
    parameter int unsigned PERIOD_LOG2 = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MISS_LIMIT  = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pwm_in_l,
    input  logic                          pwm_in_r,
    output logic signed [PERIOD_LOG2-1:0] sample_l_out,
    output logic signed [PERIOD_LOG2-1:0] sample_r_out,
    output logic                          sample_valid_out,
    input  logic                          sample_ready_in,
    output logic                          locked_out,
    output logic                          overrun_out,
    output logic                          misalign_out
);

    localparam int unsigned W  = PERIOD_LOG2;
    // miss counter only needs to hold 0..MISS_LIMIT-1
    localparam int unsigned MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync_l;
    logic [SYNC_STAGES-1:0] r_sync_r;
    logic               r_prev_l;
    logic               r_prev_r;
    logic               w_s_l;
    logic               w_s_r;
    logic               w_rise_l;
    logic               w_rise_r;
    logic               w_rise;

    logic [W-1:0]       r_phase;
    logic [W:0]         r_acc_l;
    logic [W:0]         r_acc_r;
    logic [W:0]         w_sum_l;
    logic [W:0]         w_sum_r;
    logic [W-1:0]       w_hc_l;
    logic [W-1:0]       w_hc_r;

    logic               r_bad;
    logic               w_bad_nxt;
    logic [MW-1:0]      r_miss;
    logic [MW-1:0]      w_miss_nxt;
    logic               w_load;
    logic               w_misalign;

    logic [W-1:0]       r_sample_l;
    logic [W-1:0]       r_sample_r;
    logic               r_valid;
    logic               r_overrun;
    logic               r_misalign;

    // ------------------------------------------------------------------
    // Input synchronisers; s_x is the last stage, rise_x its rising edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync_l <= '0;
            r_sync_r <= '0;
            r_prev_l <= 1'b0;
            r_prev_r <= 1'b0;
        end else begin
            r_sync_l <= {r_sync_l[SYNC_STAGES-2:0], pwm_in_l};
            r_sync_r <= {r_sync_r[SYNC_STAGES-2:0], pwm_in_r};
            r_prev_l <= w_s_l;
            r_prev_r <= w_s_r;
        end
    end

    assign w_s_l    = r_sync_l[SYNC_STAGES-1];
    assign w_s_r    = r_sync_r[SYNC_STAGES-1];
    assign w_rise_l = w_s_l & ~r_prev_l;
    assign w_rise_r = w_s_r & ~r_prev_r;
    assign w_rise   = w_rise_l | w_rise_r;

    // Final high count includes the frame-end cycle's own input; only a
    // line held high for the whole frame reaches 2**W and needs clamping.
    assign w_sum_l = r_acc_l + {{W{1'b0}}, w_s_l};
    assign w_sum_r = r_acc_r + {{W{1'b0}}, w_s_r};
    assign w_hc_l  = w_sum_l[W] ? '1 : w_sum_l[W-1:0];
    assign w_hc_r  = w_sum_r[W] ? '1 : w_sum_r[W-1:0];

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bad_nxt   = r_bad;
        w_miss_nxt  = r_miss;
        w_load      = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_rise) begin
                    w_state_nxt = ST_LOCKED;
                    w_bad_nxt   = 1'b0;
                    w_miss_nxt  = '0;
                end
            end
            ST_LOCKED: begin
                if (w_rise && (r_phase != '0)) begin
                    w_misalign = 1'b1;
                    w_bad_nxt  = 1'b1;
                end
                if (r_phase == '1) begin
                    w_bad_nxt = 1'b0;
                    if (r_bad || w_misalign) begin
                        if (r_miss == MW'(MISS_LIMIT - 1)) begin
                            // lock dropped: this frame's pair is discarded
                            w_state_nxt = ST_SEARCH;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss + MW'(1);
                            w_load     = 1'b1;
                        end
                    end else begin
                        w_miss_nxt = '0;
                        w_load     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase counter, accumulators and miss bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_phase    <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_bad      <= 1'b0;
            r_miss     <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_bad      <= w_bad_nxt;
            r_miss     <= w_miss_nxt;
            r_misalign <= w_misalign;
            if (r_state == ST_SEARCH) begin
                r_phase <= '0;
                if (w_rise) begin
                    // the rise cycle itself is phase 0 of the new frame
                    r_phase <= W'(1);
                    r_acc_l <= {{W{1'b0}}, w_s_l};
                    r_acc_r <= {{W{1'b0}}, w_s_r};
                end
            end else begin
                r_phase <= r_phase + W'(1);
                if (r_phase == '0) begin
                    r_acc_l <= {{W{1'b0}}, w_s_l};
                    r_acc_r <= {{W{1'b0}}, w_s_r};
                end else begin
                    r_acc_l <= w_sum_l;
                    r_acc_r <= w_sum_r;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pair register with valid/ready; a load wins over acceptance
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sample_l <= '0;
            r_sample_r <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= w_load && r_valid && !sample_ready_in;
            if (w_load) begin
                r_sample_l <= {~w_hc_l[W-1], w_hc_l[W-2:0]};
                r_sample_r <= {~w_hc_r[W-1], w_hc_r[W-2:0]};
                r_valid    <= 1'b1;
            end else if (r_valid && sample_ready_in) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample_l_out     = r_sample_l;
    assign sample_r_out     = r_sample_r;
    assign sample_valid_out = r_valid;
    assign locked_out       = (r_state == ST_LOCKED);
    assign overrun_out      = r_overrun;
    assign misalign_out     = r_misalign;

endmodule

// File: tb/tb_pwm_capture_stereo.sv
// tb_pwm_capture_stereo
//   Bench for pwm_capture_stereo (W=8). A reference PWM transmitter runs on
//   the same clock; each transmitted sample pair is queued when its period
//   starts and compared against the pair the DUT hands out on acceptance.
`timescale 1ns/1ps
module tb_pwm_capture_stereo;

    typedef struct {
        logic signed [7:0] l;
        logic signed [7:0] r;
    } pair_t;

    logic              clk_in;
    logic              rst_in;
    logic              pwm_in_l;
    logic              pwm_in_r;
    logic signed [7:0] sample_l_out;
    logic signed [7:0] sample_r_out;
    logic              sample_valid_out;
    logic              sample_ready_in;
    logic              locked_out;
    logic              overrun_out;
    logic              misalign_out;

    pwm_capture_stereo #(
        .PERIOD_LOG2 (8),
        .SYNC_STAGES (2),
        .MISS_LIMIT  (4)
    ) u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .pwm_in_l         (pwm_in_l),
        .pwm_in_r         (pwm_in_r),
        .sample_l_out     (sample_l_out),
        .sample_r_out     (sample_r_out),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .locked_out       (locked_out),
        .overrun_out      (overrun_out),
        .misalign_out     (misalign_out)
    );

    int                n_chk = 0;
    int                n_err = 0;

    pair_t             sb_q[$];
    logic              push_on = 1'b0;
    logic              pop_on  = 1'b0;

    logic [7:0]        tx_phase = 8'd0;
    logic [7:0]        lvl_l    = 8'd0;
    logic [7:0]        lvl_r    = 8'd0;
    logic signed [7:0] smp_l    = -8'sd128;
    logic signed [7:0] smp_r    = -8'sd128;
    int                jump_req = 0;

    int                ovr_cnt = 0;
    int                mis_cnt = 0;
    int                val_cyc = 0;
    int                acc_cnt = 0;

    logic signed [7:0] stim_l[8];
    logic signed [7:0] stim_r[8];

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference transmitter: level = sample with MSB flipped, line high for
    // the first "level" clocks of each 256-clock period.
    initial begin
        int jump_seen;
        jump_seen = 0;
        pwm_in_l  = 1'b0;
        pwm_in_r  = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (jump_req != jump_seen) begin
                jump_seen = jump_req;
                tx_phase  = tx_phase + 8'd38;
            end else begin
                tx_phase = tx_phase + 8'd1;
            end
            if (tx_phase == 8'd0) begin
                lvl_l = smp_l ^ 8'h80;
                lvl_r = smp_r ^ 8'h80;
                if (push_on) sb_q.push_back('{l: smp_l, r: smp_r});
            end
            pwm_in_l = (tx_phase < lvl_l);
            pwm_in_r = (tx_phase < lvl_r);
        end
    end

    // Output monitor: event counters and scoreboard pops on acceptance
    initial begin
        pair_t exp_p;
        forever begin
            @(negedge clk_in);
            if (overrun_out)      ovr_cnt++;
            if (misalign_out)     mis_cnt++;
            if (sample_valid_out) val_cyc++;
            if (sample_valid_out && sample_ready_in) begin
                acc_cnt++;
                if (pop_on) begin
                    check_eq("sb_avail", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        exp_p = sb_q.pop_front();
                        check_eq("sb_l", sample_l_out, exp_p.l);
                        check_eq("sb_r", sample_r_out, exp_p.r);
                    end
                end
            end
        end
    end

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic wait_phase(input int p);
        int k;
        k = 0;
        do begin
            @(posedge clk_in);
            #2;
            k++;
        end while ((tx_phase != 8'(p)) && (k < 600));
        if (k >= 600) check_eq("phase_wait", tx_phase, 32'(p));
    endtask

    task automatic wait_locked(input logic want, input int limit, input string tag);
        int k;
        k = 0;
        while ((locked_out !== want) && (k < limit)) begin
            @(posedge clk_in);
            #2;
            k++;
        end
        check_eq(tag, locked_out, want);
    endtask

    // Transmit stim_l/r[0..n-1] on consecutive periods and compare every
    // pair the DUT delivers for them.
    task automatic sb_run(input int n);
        wait_phase(200);
        for (int i = 0; i < n; i++) begin
            smp_l   = stim_l[i];
            smp_r   = stim_r[i];
            push_on = 1'b1;
            wait_phase(128);
            pop_on  = 1'b1;
            wait_phase(200);
        end
        push_on = 1'b0;
        wait_phase(128);
        pop_on = 1'b0;
        check_eq("sb_drain", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int o0;
        int m0;
        int a0;
        int v0;
        rst_in          = 1'b1;
        sample_ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        check_eq("rst_valid",  sample_valid_out, 1'b0);
        check_eq("rst_locked", locked_out, 1'b0);
        check_eq("rst_l",      sample_l_out, 8'h00);
        rst_in = 1'b0;

        // 1: acquisition and a mix of levels incl. 0 and 255
        stim_l[0] = 8'sd64;   stim_r[0] = -8'sd128;
        stim_l[1] = 8'sd127;  stim_r[1] = -8'sd1;
        stim_l[2] = -8'sd128; stim_r[2] = 8'sd0;
        stim_l[3] = -8'sd77;  stim_r[3] = 8'sd5;
        sb_run(4);
        check_eq("t1_locked", locked_out, 1'b1);
        check_eq("t1_misalign", mis_cnt, 32'd0);

        // 2: steady +127/-1, one valid cycle per period
        for (int i = 0; i < 3; i++) begin
            stim_l[i] = 8'sd127;
            stim_r[i] = -8'sd1;
        end
        sb_run(3);
        wait_phase(100);
        v0 = val_cyc;
        repeat (1024) @(posedge clk_in);
        #2;
        check_eq("t2_valid_cycles", val_cyc - v0, 32'd4);

        // 3: consumer stalls for three periods
        wait_phase(128);
        sample_ready_in = 1'b0;
        o0    = ovr_cnt;
        smp_l = 8'sd10;  smp_r = -8'sd10;
        wait_phase(128);
        smp_l = 8'sd33;  smp_r = -8'sd99;
        wait_phase(128);
        smp_l = 8'sd50;  smp_r = 8'sd20;
        wait_phase(128);
        check_eq("t3_overruns", ovr_cnt - o0, 32'd2);
        check_eq("t3_valid_held", sample_valid_out, 1'b1);
        check_eq("t3_newest_l", sample_l_out, 8'sd33);
        check_eq("t3_newest_r", sample_r_out, -8'sd99);
        a0 = acc_cnt;
        sample_ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        check_eq("t3_one_accept", acc_cnt - a0, 32'd1);
        check_eq("t3_valid_drop", sample_valid_out, 1'b0);

        // 4: transmitter phase jump of 37 cycles
        smp_l = 8'sd64;
        smp_r = -8'sd128;
        wait_phase(128);
        wait_phase(128);
        m0 = mis_cnt;
        jump_req = jump_req + 1;
        wait_locked(1'b0, 6 * 256, "t4_unlock");
        check_eq("t4_misalign_pulses", mis_cnt - m0, 32'd4);
        wait_locked(1'b1, 2 * 256, "t4_relock");
        stim_l[0] = 8'sd64;  stim_r[0] = -8'sd128;
        stim_l[1] = -8'sd20; stim_r[1] = 8'sd100;
        sb_run(2);
        check_eq("t4_no_more_misalign", mis_cnt - m0, 32'd4);

        // 5: asynchronous reset mid-frame with a pending pair
        smp_l = 8'sd64;
        smp_r = -8'sd128;
        wait_phase(100);
        sample_ready_in = 1'b0;
        wait_phase(50);
        check_eq("t5_pending", sample_valid_out, 1'b1);
        #1;
        rst_in = 1'b1;
        #1;
        check_eq("t5_rst_valid",   sample_valid_out, 1'b0);
        check_eq("t5_rst_l",       sample_l_out, 8'h00);
        check_eq("t5_rst_r",       sample_r_out, 8'h00);
        check_eq("t5_rst_locked",  locked_out, 1'b0);
        check_eq("t5_rst_overrun", overrun_out, 1'b0);
        check_eq("t5_rst_misal",   misalign_out, 1'b0);
        wait_phase(200);
        rst_in          = 1'b0;
        sample_ready_in = 1'b1;
        wait_phase(255);
        check_eq("t5_still_search", locked_out, 1'b0);
        wait_phase(8);
        check_eq("t5_relocked", locked_out, 1'b1);
        stim_l[0] = 8'sd64;  stim_r[0] = -8'sd128;
        stim_l[1] = 8'sd1;   stim_r[1] = -8'sd127;
        sb_run(2);

        // 6: no edges at all after lock
        m0 = mis_cnt;
        for (int i = 0; i < 3; i++) begin
            stim_l[i] = -8'sd128;
            stim_r[i] = -8'sd128;
        end
        sb_run(3);
        check_eq("t6_locked", locked_out, 1'b1);
        check_eq("t6_misalign", mis_cnt - m0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
